// File: rtl/stepper_axis_pulser_pkg.sv
// Shared definitions for the single-axis step/direction pulse generator.
package stepper_axis_pulser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } state_t;

  localparam logic DIR_POS = 1'b1;
  localparam logic DIR_NEG = 1'b0;

endpackage

// File: rtl/stepper_axis_pulser_timer.sv
// Loadable down-counter shared by the SETUP, HIGH and LOW phases.
module stepper_axis_pulser_timer #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] count;

  // Counts down to zero and parks there; a load always wins over the decrement.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/stepper_axis_pulser.sv
// Step/direction pulse generator for one plotter axis: timed STEP pulses, DIR setup, signed position.
module stepper_axis_pulser
  import stepper_axis_pulser_pkg::*;
#(
  parameter int POS_W            = 32,
  parameter int STEP_HIGH_CYCLES = 200,
  parameter int DIR_SETUP_CYCLES = 100,
  parameter int MIN_PERIOD       = 1000
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             move_pos,
  input  logic             move_neg,
  input  logic [POS_W-1:0] period,
  input  logic             zero_pos,
  output logic             step_pin,
  output logic             dir_pin,
  output logic [POS_W-1:0] position,
  output logic             busy,
  output logic             step_done,
  output state_t           state
);

  localparam int FLOOR_INT = (MIN_PERIOD > STEP_HIGH_CYCLES + 1) ? MIN_PERIOD : STEP_HIGH_CYCLES + 1;
  localparam logic [POS_W-1:0] PERIOD_FLOOR = POS_W'(FLOOR_INT);
  localparam logic [POS_W-1:0] HIGH_LOAD    = POS_W'(STEP_HIGH_CYCLES - 1);
  localparam logic [POS_W-1:0] SETUP_LOAD   = POS_W'(DIR_SETUP_CYCLES);
  localparam logic [POS_W-1:0] LOW_OFFSET   = POS_W'(STEP_HIGH_CYCLES + 1);

  logic             req_valid;
  logic             req_dir;
  logic [POS_W-1:0] eff_period;
  logic [POS_W-1:0] period_q;
  logic             fire;
  logic             timer_load;
  logic [POS_W-1:0] timer_value;
  logic             timer_expired;

  assign req_valid  = (move_pos ^ move_neg) && (period != '0);
  assign req_dir    = move_pos ? DIR_POS : DIR_NEG;
  assign eff_period = (period > PERIOD_FLOOR) ? period : PERIOD_FLOOR;
  assign busy       = (state != ST_IDLE);

  // fire marks the edge on which STEP rises: the HIGH entry cycle from IDLE (step_pin still 0),
  // the end of SETUP, or the end of LOW with a same-direction request pending.
  always_comb begin
    fire        = 1'b0;
    timer_load  = 1'b0;
    timer_value = '0;
    case (state)
      ST_IDLE: begin
        if (req_valid && req_dir != dir_pin) begin
          timer_load  = 1'b1;
          timer_value = SETUP_LOAD;
        end
      end
      ST_SETUP: fire = timer_expired;
      ST_HIGH: begin
        if (!step_pin) begin
          fire = 1'b1;
        end else if (timer_expired) begin
          timer_load  = 1'b1;
          timer_value = period_q - LOW_OFFSET;
        end
      end
      ST_LOW: begin
        if (timer_expired && req_valid) begin
          if (req_dir == dir_pin) begin
            fire = 1'b1;
          end else begin
            timer_load  = 1'b1;
            timer_value = SETUP_LOAD;
          end
        end
      end
      default: ;
    endcase
    if (fire) begin
      timer_load  = 1'b1;
      timer_value = HIGH_LOAD;
    end
  end

  stepper_axis_pulser_timer #(.W(POS_W)) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (timer_load),
    .value   (timer_value),
    .expired (timer_expired)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      step_pin  <= 1'b0;
      dir_pin   <= DIR_NEG;
      position  <= '0;
      step_done <= 1'b0;
      period_q  <= '0;
    end else begin
      step_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if (req_dir == dir_pin) begin
              state <= ST_HIGH;
            end else begin
              dir_pin <= req_dir;
              state   <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          if (timer_expired) begin
            state    <= ST_HIGH;
            step_pin <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (!step_pin) begin
            step_pin <= 1'b1;
          end else if (timer_expired) begin
            step_pin <= 1'b0;
            state    <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (timer_expired) begin
            step_done <= 1'b1;
            if (req_valid && req_dir == dir_pin) begin
              state    <= ST_HIGH;
              step_pin <= 1'b1;
            end else if (req_valid) begin
              dir_pin <= req_dir;
              state   <= ST_SETUP;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (fire) begin
        period_q <= eff_period;
      end
      // A clear request beats the step that would otherwise be counted on the same edge.
      if (zero_pos) begin
        position <= '0;
      end else if (fire) begin
        position <= (dir_pin == DIR_POS) ? position + POS_W'(1) : position - POS_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_stepper_axis_pulser.sv
// Directed bench for stepper_axis_pulser with STEP_HIGH=4, DIR_SETUP=3, MIN_PERIOD=10.
module tb_stepper_axis_pulser;
  import stepper_axis_pulser_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        move_pos;
  logic        move_neg;
  logic [31:0] period;
  logic        zero_pos;
  logic        step_pin;
  logic        dir_pin;
  logic [31:0] position;
  logic        busy;
  logic        step_done;
  state_t      dbg_state;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  int rise_q[$];
  int hl_q[$];
  int done_cnt = 0;
  int hi_cnt   = 0;
  logic prev_step = 1'b0;

  stepper_axis_pulser #(
    .POS_W(32), .STEP_HIGH_CYCLES(4), .DIR_SETUP_CYCLES(3), .MIN_PERIOD(10)
  ) dut (
    .clock(clock), .reset_n(reset_n), .move_pos(move_pos), .move_neg(move_neg),
    .period(period), .zero_pos(zero_pos), .step_pin(step_pin), .dir_pin(dir_pin),
    .position(position), .busy(busy), .step_done(step_done), .state(dbg_state)
  );

  // clock / reset block
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // STEP monitor: rise cycle, pulse width, step_done count
  always @(negedge clock) begin
    if (step_pin === 1'b1 && prev_step !== 1'b1) rise_q.push_back(cyc);
    if (step_pin === 1'b1) hi_cnt = hi_cnt + 1;
    else if (prev_step === 1'b1) begin
      hl_q.push_back(hi_cnt);
      hi_cnt = 0;
    end
    if (step_done === 1'b1) done_cnt = done_cnt + 1;
    prev_step = step_pin;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic clear_mon();
    rise_q.delete();
    hl_q.delete();
    done_cnt = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, expected 0", busy, n);
    end
    @(negedge clock);
  endtask

  task automatic zero_now();
    zero_pos = 1'b1;
    @(negedge clock);
    zero_pos = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; move_pos = 1'b1; move_neg = 1'b0; period = 32'd20; zero_pos = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checks++;
      if ({step_pin, dir_pin, busy, step_done, position} !== 36'd0) begin
        fails++;
        $display("FAIL reset_outputs: step=%b dir=%b busy=%b done=%b pos=%h, expected all 0",
                 step_pin, dir_pin, busy, step_done, position);
      end
    end
    move_pos = 1'b0;
    reset_n  = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_steady_pos();
    int k0;
    clear_mon();
    k0 = cyc;
    move_pos = 1'b1; period = 32'd20;
    wait_until(k0 + 1);
    checks++;
    if (dir_pin !== 1'b1 || step_pin !== 1'b0) begin
      fails++;
      $display("FAIL steady_dir_first: dir=%b step=%b, expected dir=1 step=0", dir_pin, step_pin);
    end
    wait_until(k0 + 100);
    move_pos = 1'b0;
    wait_idle();
    checks++;
    if (rise_q.size() !== 5) begin
      fails++;
      $display("FAIL steady_rise_count: got %0d expected 5", rise_q.size());
    end
    checks++;
    if (rise_q.size() > 0 && rise_q[0] !== k0 + 5) begin
      fails++;
      $display("FAIL steady_first_rise: got cycle %0d expected %0d", rise_q[0], k0 + 5);
    end
    for (int i = 1; i < rise_q.size(); i++) begin
      checks++;
      if (rise_q[i] - rise_q[i-1] !== 20) begin
        fails++;
        $display("FAIL steady_spacing: edge %0d gap %0d expected 20", i, rise_q[i] - rise_q[i-1]);
      end
    end
    for (int i = 0; i < hl_q.size(); i++) begin
      checks++;
      if (hl_q[i] !== 4) begin
        fails++;
        $display("FAIL steady_high_len: pulse %0d width %0d expected 4", i, hl_q[i]);
      end
    end
    checks++;
    if (done_cnt !== 5) begin
      fails++;
      $display("FAIL steady_done_count: got %0d expected 5", done_cnt);
    end
    checks++;
    if (position !== 32'd5) begin
      fails++;
      $display("FAIL steady_position: got %h expected 00000005", position);
    end
  endtask

  task automatic test_dir_change_clamp();
    int k0;
    zero_now();
    clear_mon();
    k0 = cyc;
    move_neg = 1'b1; period = 32'd3;
    wait_until(k0 + 1);
    checks++;
    if (dir_pin !== 1'b0 || step_pin !== 1'b0) begin
      fails++;
      $display("FAIL dir_change_first: dir=%b step=%b, expected dir=0 step=0", dir_pin, step_pin);
    end
    wait_until(k0 + 4);
    checks++;
    if (step_pin !== 1'b0) begin
      fails++;
      $display("FAIL dir_setup_hold: step=%b expected 0", step_pin);
    end
    wait_until(k0 + 5);
    checks++;
    if (step_pin !== 1'b1 || position !== 32'hFFFF_FFFF) begin
      fails++;
      $display("FAIL dir_first_step: step=%b pos=%h, expected step=1 pos=ffffffff", step_pin, position);
    end
    wait_until(k0 + 15);
    checks++;
    if (position !== 32'hFFFF_FFFE) begin
      fails++;
      $display("FAIL dir_second_step: pos=%h expected fffffffe", position);
    end
    wait_until(k0 + 25);
    move_neg = 1'b0;
    wait_idle();
    checks++;
    if (rise_q.size() !== 3) begin
      fails++;
      $display("FAIL clamp_rise_count: got %0d expected 3", rise_q.size());
    end
    for (int i = 1; i < rise_q.size(); i++) begin
      checks++;
      if (rise_q[i] - rise_q[i-1] !== 10) begin
        fails++;
        $display("FAIL clamp_spacing: edge %0d gap %0d expected 10", i, rise_q[i] - rise_q[i-1]);
      end
    end
    checks++;
    if (position !== 32'hFFFF_FFFD) begin
      fails++;
      $display("FAIL clamp_position: got %h expected fffffffd", position);
    end
  endtask

  task automatic test_drop_mid_step();
    int k0;
    zero_now();
    clear_mon();
    k0 = cyc;
    move_pos = 1'b1; period = 32'd20;
    wait_until(k0 + 7);
    move_pos = 1'b0;
    wait_until(k0 + 24);
    checks++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL drop_busy_low_phase: busy=%b expected 1", busy);
    end
    wait_until(k0 + 25);
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL drop_busy_end: busy=%b expected 0", busy);
    end
    wait_idle();
    checks++;
    if (rise_q.size() !== 1 || hl_q.size() !== 1 || (hl_q.size() > 0 && hl_q[0] !== 4)) begin
      fails++;
      $display("FAIL drop_pulse: rises=%0d pulses=%0d, expected one pulse of width 4",
               rise_q.size(), hl_q.size());
    end
    checks++;
    if (done_cnt !== 1 || position !== 32'd1) begin
      fails++;
      $display("FAIL drop_position: done=%0d pos=%h, expected done=1 pos=00000001", done_cnt, position);
    end
  endtask

  task automatic test_conflicts();
    int k0;
    clear_mon();
    move_pos = 1'b1; move_neg = 1'b1; period = 32'd20;
    repeat (10) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || step_pin !== 1'b0 || rise_q.size() !== 0) begin
      fails++;
      $display("FAIL both_dirs: busy=%b step=%b rises=%0d, expected 0 0 0", busy, step_pin, rise_q.size());
    end
    move_pos = 1'b0; move_neg = 1'b0;
    zero_now();
    checks++;
    if (position !== 32'd0) begin
      fails++;
      $display("FAIL zero_idle: pos=%h expected 00000000", position);
    end
    k0 = cyc;
    move_pos = 1'b1; period = 32'd10;
    wait_until(k0 + 62);
    checks++;
    if (position !== 32'd7) begin
      fails++;
      $display("FAIL zero_pre_position: pos=%h expected 00000007", position);
    end
    wait_until(k0 + 71);
    zero_pos = 1'b1;
    wait_until(k0 + 72);
    zero_pos = 1'b0; move_pos = 1'b0;
    checks++;
    if (position !== 32'd0 || step_pin !== 1'b1) begin
      fails++;
      $display("FAIL zero_vs_step: pos=%h step=%b, expected pos=00000000 step=1", position, step_pin);
    end
    wait_idle();
    checks++;
    if (position !== 32'd0 || rise_q.size() !== 8) begin
      fails++;
      $display("FAIL zero_after: pos=%h rises=%0d, expected pos=00000000 rises=8", position, rise_q.size());
    end
  endtask

  task automatic test_wrap_abort();
    int k0;
    k0 = cyc;
    move_neg = 1'b1; period = 32'd10;
    wait_until(k0 + 5);
    move_neg = 1'b0;
    checks++;
    if (position !== 32'hFFFF_FFFF) begin
      fails++;
      $display("FAIL wrap_down: pos=%h expected ffffffff", position);
    end
    wait_idle();
    k0 = cyc;
    move_pos = 1'b1;
    wait_until(k0 + 5);
    move_pos = 1'b0;
    checks++;
    if (position !== 32'd0) begin
      fails++;
      $display("FAIL wrap_up: pos=%h expected 00000000", position);
    end
    wait_idle();
    k0 = cyc;
    move_pos = 1'b1;
    wait_until(k0 + 3);
    checks++;
    if (step_pin !== 1'b1 || position !== 32'd1) begin
      fails++;
      $display("FAIL abort_pre: step=%b pos=%h, expected step=1 pos=00000001", step_pin, position);
    end
    reset_n = 1'b0;
    wait_until(k0 + 4);
    checks++;
    if (step_pin !== 1'b0 || position !== 32'd0 || busy !== 1'b0 || dir_pin !== 1'b0 || dbg_state !== ST_IDLE) begin
      fails++;
      $display("FAIL abort_reset: step=%b pos=%h busy=%b dir=%b state=%0d, expected all 0",
               step_pin, position, busy, dir_pin, dbg_state);
    end
    move_pos = 1'b0;
    reset_n  = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_steady_pos();
    test_dir_change_clamp();
    test_drop_mid_step();
    test_conflicts();
    test_wrap_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
